// File: rtl/oport_uart_tx_pkg.sv
// oport_uart_tx_pkg: shared payload width, default bit period and transmitter FSM encodings.
package oport_uart_tx_pkg;
   localparam int DATA_LEN        = 4;
   localparam int TX_CLKS_PER_BIT = 4;
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;
endpackage

// File: rtl/oport_uart_tx_fifo.sv
// oport_fifo: W x DEPTH nibble FIFO with an up/down occupancy counter; head entry is read combinationally.
module oport_fifo #(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic [W-1:0]              wdata_i,
   output logic [W-1:0]              rdata_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   level_q;
   always_ff @(posedge CLK) if (push_i) mem_q[wptr_q] <= wdata_i;
   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + 1'b1;
         if (pop_i) rptr_q <= rptr_q + 1'b1;
         level_q <= level_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
      end
   end
   assign rdata_o = mem_q[rptr_q];
   assign full_o  = level_q == FULL_LVL;
   assign empty_o = level_q == '0;
   assign level_o = level_q;
endmodule

// File: rtl/oport_uart_tx.sv
// oport_uart_tx: queues OPORT stores and serialises each nibble onto TXD (start, LSB-first data, stop).
// Defining OPORT_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module oport_uart_tx
   import oport_uart_tx_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [DATA_LEN-1:0]           WDATA,
   input  logic                          WE,
   output logic                          TXD,
   output logic                          BUSY,
   output logic                          FULL,
   output logic                          OVF,
   output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);
   localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = DATA_LEN > 1 ? $clog2(DATA_LEN) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_LEN - 1);
   tx_state_e           state_q;
   logic [CW-1:0]       baud_q;
   logic [BW-1:0]       bit_q;
   logic [DATA_LEN-1:0] shift_q, rdata;
   logic                txd_q, txd_d, ovf_q, empty, pop, push, baud_last;
`ifdef OPORT_TX_PARITY_EN
   logic                par_q;
`endif
   // A pop frees a slot at the same edge, so a write into a full FIFO is still accepted then.
   assign pop       = state_q == TX_IDLE && !empty;
   assign push      = WE && (!FULL || pop);
   assign baud_last = baud_q == BAUD_LAST;
   oport_fifo #(.W(DATA_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK(CLK), .RST(RST), .push_i(push), .pop_i(pop), .wdata_i(WDATA),
      .rdata_o(rdata), .full_o(FULL), .empty_o(empty), .level_o(LEVEL)
   );
   always_comb begin
      txd_d = 1'b1;
      if (state_q == TX_START) txd_d = 1'b0;
      else if (state_q == TX_DATA) txd_d = shift_q[0];
`ifdef OPORT_TX_PARITY_EN
      else if (state_q == TX_PARITY) txd_d = par_q;
`endif
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
`ifdef OPORT_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         txd_q  <= txd_d;
         baud_q <= (state_q == TX_IDLE || baud_last) ? '0 : baud_q + 1'b1;
         if (WE && FULL && !pop) ovf_q <= 1'b1;
         case (state_q)
            TX_IDLE: if (!empty) begin
               shift_q <= rdata;
               bit_q   <= '0;
               state_q <= TX_START;
`ifdef OPORT_TX_PARITY_EN
               par_q   <= ^rdata;
`endif
            end
            TX_START: if (baud_last) state_q <= TX_DATA;
            TX_DATA: if (baud_last) begin
               shift_q <= shift_q >> 1;
               bit_q   <= bit_q + 1'b1;
`ifdef OPORT_TX_PARITY_EN
               if (bit_q == BIT_LAST) state_q <= TX_PARITY;
`else
               if (bit_q == BIT_LAST) state_q <= TX_STOP;
`endif
            end
`ifdef OPORT_TX_PARITY_EN
            TX_PARITY: if (baud_last) state_q <= TX_STOP;
`endif
            TX_STOP: if (baud_last) state_q <= TX_IDLE;
            default: state_q <= TX_IDLE;
         endcase
      end
   end
   assign TXD  = txd_q;
   assign OVF  = ovf_q;
   assign BUSY = state_q != TX_IDLE || !empty;
endmodule

// File: tb/tb_oport_uart_tx.sv
// tb_oport_uart_tx: frame-level model checked every cycle on two instances (4 and 1 clocks per bit),
// plus literal waveform points; honours OPORT_TX_PARITY_EN.
module tb_oport_uart_tx;
   localparam int DL = 4;
`ifdef OPORT_TX_PARITY_EN
   localparam int NB = DL + 3;
`else
   localparam int NB = DL + 2;
`endif
   logic       clk = 1'b0, rst = 1'b1;
   logic       we [2];
   logic [3:0] wd [2];
   logic       txd [2], busy [2], full [2], ovf [2];
   logic [2:0] level [2];
   int checks = 0, errors = 0;
   bit chk_en = 1'b0;
   always #5 clk = ~clk;
   oport_uart_tx #(.FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut0 (
      .CLK(clk), .RST(rst), .WDATA(wd[0]), .WE(we[0]), .TXD(txd[0]),
      .BUSY(busy[0]), .FULL(full[0]), .OVF(ovf[0]), .LEVEL(level[0]));
   oport_uart_tx #(.FIFO_DEPTH(4), .CLKS_PER_BIT(1)) dut1 (
      .CLK(clk), .RST(rst), .WDATA(wd[1]), .WE(we[1]), .TXD(txd[1]),
      .BUSY(busy[1]), .FULL(full[1]), .OVF(ovf[1]), .LEVEL(level[1]));
   // Model: a queue of nibbles, a frame being sent (bit vector + cycles since pop), a sticky drop flag.
   int         cpb [2] = '{4, 1};
   int         mcnt [2], left [2], el [2];
   logic [3:0] mq [2][4];
   logic [7:0] fb [2];
   logic       movf [2];
   function automatic logic [7:0] frame(logic [3:0] d);
`ifdef OPORT_TX_PARITY_EN
      return {2'b01, ^d, d, 1'b0};
`else
      return {3'b001, d, 1'b0};
`endif
   endfunction
   function automatic logic exp_txd(int i);
      return (el[i] >= 1 && el[i] <= NB * cpb[i]) ? fb[i][(el[i] - 1) / cpb[i]] : 1'b1;
   endfunction
   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wr(int i, logic [3:0] d);
      we[i] = 1'b1;
      wd[i] = d;
      @(negedge clk);
      we[i] = 1'b0;
   endtask
   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mcnt[i] = 0; left[i] = 0; el[i] = 1000; movf[i] = 1'b0;
         end else begin
            if (el[i] < 1000) el[i]++;
            if (left[i] > 0) left[i]--;
            else if (mcnt[i] > 0) begin
               fb[i] = frame(mq[i][0]);
               for (int j = 0; j < 3; j++) mq[i][j] = mq[i][j + 1];
               mcnt[i]--;
               el[i] = 0;
               left[i] = NB * cpb[i];
            end
            if (we[i]) begin
               if (mcnt[i] < 4) begin
                  mq[i][mcnt[i]] = wd[i];
                  mcnt[i]++;
               end else movf[i] = 1'b1;
            end
         end
      end
   end
   initial forever begin
      @(negedge clk);
      if (chk_en)
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("txd%0d", k), 8'(txd[k]), 8'(exp_txd(k)));
            chk($sformatf("busy%0d", k), 8'(busy[k]), 8'(left[k] > 0 || mcnt[k] > 0));
            chk($sformatf("full%0d", k), 8'(full[k]), 8'(mcnt[k] == 4));
            chk($sformatf("ovf%0d", k), 8'(ovf[k]), 8'(movf[k]));
            chk($sformatf("level%0d", k), 8'(level[k]), 8'(mcnt[k]));
         end
   end
   int exp6 [$];
   initial begin
`ifdef OPORT_TX_PARITY_EN
      exp6 = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
`else
      exp6 = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
`endif
      we[0] = 1'b0; we[1] = 1'b0; wd[0] = '0; wd[1] = '0;
      tick(2);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_txd", 8'(txd[0]), 8'd1);
      chk("rst_busy", 8'(busy[0]), 8'd0);
      chk("rst_full", 8'(full[0]), 8'd0);
      chk("rst_ovf", 8'(ovf[0]), 8'd0);
      chk("rst_level", 8'(level[0]), 8'd0);
      // Single 4'hA frame: start 0, data 0,1,0,1, stop 1, four cycles each
      wr(0, 4'hA);
      chk("t1_level", 8'(level[0]), 8'd1);
      tick(1); chk("t1_pop_idle", 8'(txd[0]), 8'd1);
      tick(1); chk("t1_start", 8'(txd[0]), 8'd0);
      tick(3); chk("t1_start_end", 8'(txd[0]), 8'd0);
      tick(1); chk("t1_b0", 8'(txd[0]), 8'd0);
      tick(4); chk("t1_b1", 8'(txd[0]), 8'd1);
      tick(4); chk("t1_b2", 8'(txd[0]), 8'd0);
      tick(4); chk("t1_b3", 8'(txd[0]), 8'd1);
`ifdef OPORT_TX_PARITY_EN
      tick(4); chk("t5_parA", 8'(txd[0]), 8'd0);
`endif
      tick(4); chk("t1_stop", 8'(txd[0]), 8'd1);
      chk("t1_busy_stop", 8'(busy[0]), 8'd1);
      tick(4); chk("t1_busy_done", 8'(busy[0]), 8'd0);
      // Five back-to-back stores while idle
      for (int d = 1; d <= 5; d++) wr(0, 4'(d));
      chk("t2_level_peak", 8'(level[0]), 8'd4);
      chk("t2_full", 8'(full[0]), 8'd1);
      tick(5 * NB * 4 + 10);
      chk("t2_drained", 8'(busy[0]), 8'd0);
      chk("t2_ovf", 8'(ovf[0]), 8'd0);
      // Overflow: sixth store dropped; a store on a pop edge is kept
      for (int d = 1; d <= 6; d++) wr(0, 4'(d));
      chk("t3_ovf", 8'(ovf[0]), 8'd1);
      chk("t3_level", 8'(level[0]), 8'd4);
      tick(NB * 4 - 4);
      wr(0, 4'h9);
      chk("t3_pop_push_level", 8'(level[0]), 8'd4);
      tick(1); chk("t3_level_after", 8'(level[0]), 8'd4);
      tick(5 * NB * 4 + 10);
      chk("t3_drained", 8'(busy[0]), 8'd0);
      chk("t3_ovf_sticky", 8'(ovf[0]), 8'd1);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("t3_ovf_cleared", 8'(ovf[0]), 8'd0);
      // Reset mid-DATA with two entries queued
      for (int d = 1; d <= 3; d++) wr(0, 4'(d));
      tick(8);
      chk("t4_queued", 8'(level[0]), 8'd2);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("t4_txd", 8'(txd[0]), 8'd1);
      chk("t4_level", 8'(level[0]), 8'd0);
      chk("t4_busy", 8'(busy[0]), 8'd0);
      tick(60);
      chk("t4_quiet", 8'(busy[0]), 8'd0);
      chk("t4_quiet_txd", 8'(txd[0]), 8'd1);
`ifdef OPORT_TX_PARITY_EN
      wr(0, 4'h7);
      tick(22); chk("t5_par7", 8'(txd[0]), 8'd1);
      tick(6); chk("t5_busy_stop", 8'(busy[0]), 8'd1);
      tick(2); chk("t5_busy_done", 8'(busy[0]), 8'd0);
`endif
      // One clock per bit, back-to-back 4'hF then 4'h0
      wr(1, 4'hF);
      wr(1, 4'h0);
      foreach (exp6[k]) begin
         tick(1);
         chk($sformatf("t6_bit%0d", k), 8'(txd[1]), 8'(exp6[k]));
      end
      tick(5);
      chk("t6_busy_done", 8'(busy[1]), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
